// File: rtl/speech256_sequencer.sv
// Allophone FIFO and load sequencer in front of the speech core.
// Buffers 6-bit host codes and issues them one per ldq handshake as a single-cycle strobe.
module speech256_sequencer #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_an,
   input  logic [5:0]        wr_data,
   input  logic              wr_en,
   input  logic              flush,
   input  logic              ldq,
   output logic [5:0]        data_out,
   output logic              data_stb,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              busy,
   output logic              overflow,
   output logic              ack_err
);

   localparam int unsigned CODE_W = 6;
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned TMR_W  = 16;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      STROBE     = 2'd1,
      WAIT_ACK   = 2'd2,
      WAIT_READY = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [CODE_W-1:0]   data_out_d;
   logic                data_stb_d;
   logic                overflow_d;
   logic                ack_err_d;
   logic                wr_accept;
   logic [CODE_W-1:0]   mem [DEPTH];

   // Occupancy flags derive from the registered pointers only.
   assign level     = wr_ptr_q - rd_ptr_q;
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (level == PTR_W'(DEPTH));
   assign busy      = !empty || (state_q != IDLE) || !ldq;
   assign wr_accept = wr_en && !full && !flush;

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
      end
   end

   // Next-state: flush wins over writes and issue; a full FIFO rejects writes even when popping.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      timer_d    = timer_q;
      data_out_d = data_out;
      data_stb_d = 1'b0;
      overflow_d = overflow;
      ack_err_d  = ack_err;

      if (flush) begin
         state_d    = IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         timer_d    = '0;
         overflow_d = 1'b0;
         ack_err_d  = 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (wr_en && full) begin
            overflow_d = 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (!empty && ldq) begin
                  data_out_d = mem[rd_ptr_q[ADDR_W-1:0]];
                  rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                  data_stb_d = 1'b1;
                  state_d    = STROBE;
               end
            end
            STROBE: begin
               timer_d = '0;
               state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
               // A core that never drops ldq forfeits the code; it is not re-issued.
               if (!ldq) begin
                  state_d = WAIT_READY;
               end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                  ack_err_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            WAIT_READY: begin
               if (ldq) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         timer_q  <= '0;
         data_out <= '0;
         data_stb <= 1'b0;
         overflow <= 1'b0;
         ack_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         timer_q  <= timer_d;
         data_out <= data_out_d;
         data_stb <= data_stb_d;
         overflow <= overflow_d;
         ack_err  <= ack_err_d;
      end
   end

endmodule

// File: tb/tb_speech256_sequencer.sv
// Directed self-checking bench for speech256_sequencer (DEPTH=16, ACK_TIMEOUT=10).
module tb_speech256_sequencer;

   logic        clk = 1'b0;
   logic        rst_an;
   logic [5:0]  wr_data;
   logic        wr_en;
   logic        flush;
   logic        ldq;
   logic [5:0]  data_out;
   logic        data_stb;
   logic        full;
   logic        empty;
   logic [4:0]  level;
   logic        busy;
   logic        overflow;
   logic        ack_err;

   int unsigned n_checks  = 0;
   int unsigned n_errors  = 0;
   int unsigned exp_cnt   = 0;
   int unsigned double_stb = 0;
   logic        prev_stb  = 1'b0;
   logic [5:0]  issued[$];

   speech256_sequencer #(.DEPTH(16), .ADDR_W(4), .ACK_TIMEOUT(10)) dut (
      .clk      (clk),
      .rst_an   (rst_an),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .flush    (flush),
      .ldq      (ldq),
      .data_out (data_out),
      .data_stb (data_stb),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .busy     (busy),
      .overflow (overflow),
      .ack_err  (ack_err)
   );

   always #5 clk = ~clk;

   // Record every strobe seen by the core and any strobe wider than one cycle.
   always @(negedge clk) begin
      if (data_stb === 1'b1) begin
         issued.push_back(data_out);
         if (prev_stb) double_stb++;
      end
      prev_stb = (data_stb === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] code);
      wr_data = code;
      wr_en   = 1'b1;
      tick(1);
      wr_en   = 1'b0;
   endtask

   task automatic wait_stb(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick(1);
         if (data_stb === 1'b1) seen = 1'b1;
      end
   endtask

   // Core model: raise ldq, expect one strobe with the given code, then drop ldq for two cycles.
   task automatic handshake(input string tag, input logic [5:0] code);
      bit seen;
      ldq = 1'b1;
      wait_stb(8, seen);
      check({tag, "_seen"}, 32'(seen), 32'd1);
      check({tag, "_code"}, 32'(data_out), 32'(code));
      exp_cnt++;
      tick(1);
      ldq = 1'b0;
      tick(2);
   endtask

   initial begin
      bit seen;
      int unsigned n_before;
      logic [5:0] code;

      rst_an = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; ldq = 1'b0;
      #12;
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_stb",      32'(data_stb), 32'd0);
      check("rst_empty",    32'(empty),    32'd1);
      check("rst_full",     32'(full),     32'd0);
      check("rst_level",    32'(level),    32'd0);
      check("rst_flags",    32'({overflow, ack_err}), 32'd0);
      check("rst_busy_ldq0", 32'(busy),    32'd1);
      ldq = 1'b1;
      #1;
      check("rst_busy_ldq1", 32'(busy),    32'd0);
      rst_an = 1'b1;
      tick(1);

      // Single issue latency and handshake.
      wr(6'd6);
      check("t1_stb_early", 32'(data_stb), 32'd0);
      tick(1);
      check("t1_stb",       32'(data_stb), 32'd1);
      check("t1_code",      32'(data_out), 32'd6);
      exp_cnt++;
      tick(1);
      check("t1_stb_width", 32'(data_stb), 32'd0);
      ldq = 1'b0;
      tick(100);
      check("t1_busy_low",  32'(busy),     32'd1);
      ldq = 1'b1;
      tick(1);
      check("t1_busy_done", 32'(busy),     32'd0);
      tick(5);
      check("t1_count",     32'(issued.size()), 32'(exp_cnt));

      // Burst of five held back by ldq low, then released in order.
      ldq = 1'b0;
      tick(1);
      for (int i = 1; i <= 5; i++) wr(6'(i));
      check("t2_level", 32'(level), 32'd5);
      for (int i = 1; i <= 5; i++) handshake("t2", 6'(i));
      check("t2_empty", 32'(empty), 32'd1);
      check("t2_count", 32'(issued.size()), 32'(exp_cnt));

      // Fill to full, overflow on the 17th write, drain.
      for (int i = 1; i <= 16; i++) wr(6'(i));
      check("t3_full",      32'(full),     32'd1);
      check("t3_level16",   32'(level),    32'd16);
      check("t3_no_ovf",    32'(overflow), 32'd0);
      wr(6'd17);
      check("t3_ovf",       32'(overflow), 32'd1);
      check("t3_level_ovf", 32'(level),    32'd16);
      for (int i = 1; i <= 16; i++) handshake("t3", 6'(i));
      ldq = 1'b1;
      tick(6);
      check("t3_empty",     32'(empty),    32'd1);
      check("t3_count",     32'(issued.size()), 32'(exp_cnt));
      check("t3_ovf_hold",  32'(overflow), 32'd1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("t3_ovf_clr",   32'(overflow), 32'd0);

      // Acknowledge timeout with a core that ignores strobes.
      ldq = 1'b0;
      tick(1);
      wr(6'd40);
      wr(6'd41);
      ldq = 1'b1;
      tick(1);
      check("t4_stb1",      32'(data_stb), 32'd1);
      check("t4_code1",     32'(data_out), 32'd40);
      exp_cnt++;
      tick(1);
      tick(9);
      check("t4_err_early", 32'(ack_err),  32'd0);
      tick(1);
      check("t4_err",       32'(ack_err),  32'd1);
      tick(1);
      check("t4_stb2",      32'(data_stb), 32'd1);
      check("t4_code2",     32'(data_out), 32'd41);
      exp_cnt++;
      tick(15);
      check("t4_err_hold",  32'(ack_err),  32'd1);
      check("t4_empty",     32'(empty),    32'd1);
      check("t4_count",     32'(issued.size()), 32'(exp_cnt));
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("t4_err_clr",   32'(ack_err),  32'd0);

      // Flush in the strobe cycle together with a write.
      wr(6'd7);
      tick(1);
      exp_cnt++;
      tick(12);
      check("t5_err_pre",   32'(ack_err),  32'd1);
      wr(6'd8);
      tick(1);
      check("t5_stb",       32'(data_stb), 32'd1);
      exp_cnt++;
      flush = 1'b1; wr_en = 1'b1; wr_data = 6'd9;
      tick(1);
      flush = 1'b0; wr_en = 1'b0;
      check("t5_stb_off",   32'(data_stb), 32'd0);
      check("t5_empty",     32'(empty),    32'd1);
      check("t5_flags",     32'({overflow, ack_err}), 32'd0);
      n_before = issued.size();
      tick(6);
      check("t5_no9",       32'(issued.size()), 32'(n_before));
      check("t5_data_hold", 32'(data_out), 32'd8);
      check("t5_count",     32'(issued.size()), 32'(exp_cnt));

      // Pointer wrap across 40 write/issue pairs.
      ldq = 1'b0;
      tick(1);
      for (int i = 0; i < 40; i++) begin
         code = 6'((i * 7 + 3) % 64);
         wr(code);
         handshake("t6", code);
      end
      ldq = 1'b1;
      tick(4);
      check("t6_count",     32'(issued.size()), 32'(exp_cnt));
      check("t6_empty",     32'(empty),    32'd1);
      check("stb_one_cycle", 32'(double_stb), 32'd0);

      // Asynchronous reset aborts a strobe in progress.
      wr(6'd5);
      tick(1);
      check("t7_stb",       32'(data_stb), 32'd1);
      #2 rst_an = 1'b0;
      #1;
      check("t7_stb_abort", 32'(data_stb), 32'd0);
      check("t7_data_rst",  32'(data_out), 32'd0);
      check("t7_level_rst", 32'(level),    32'd0);
      #1 rst_an = 1'b1;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
